// File: rtl/iter_divider_pkg.sv
// Shared types and helpers for the iterative radix-2 restoring divider.
package iter_divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } div_state_e;

  // Width of the iteration counter; a 1-bit divider still needs one counter bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/iter_divider_sign_fix.sv
// Combinational conditional two's-complement negate, used for operand
// magnitudes and for the final quotient/remainder sign fixup.
module iter_divider_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider with a dividend/divisor/dout stream
// handshake; one quotient bit per cycle, one-cycle result pulse, no back-pressure.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    b_mag_q, b_mag_d;
  logic                qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*WIDTH-1:0]  dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;

  logic                a_neg, b_neg, accept;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      rem_shift;
  logic                ge;
  logic [WIDTH-1:0]    rem_step, quo_step, q_fixed, r_fixed;

  assign a_neg  = SIGNED && s_axis_dividend_tdata[WIDTH-1];
  assign b_neg  = SIGNED && s_axis_divisor_tdata[WIDTH-1];
  assign accept = (state_q == StIdle) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

  iter_divider_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .value  (s_axis_dividend_tdata),
    .negate (a_neg),
    .result (a_mag)
  );

  iter_divider_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .value  (s_axis_divisor_tdata),
    .negate (b_neg),
    .result (b_mag)
  );

  // quo_q starts as |a| and is shifted out MSB-first while quotient bits shift in.
  // After a successful trial the remainder is below |b|, so WIDTH bits hold the difference.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign ge        = rem_shift >= {1'b0, b_mag_q};
  assign rem_step  = ge ? (rem_shift[WIDTH-1:0] - b_mag_q) : rem_shift[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], ge};

  iter_divider_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .value  (quo_step),
    .negate (qneg_q),
    .result (q_fixed)
  );

  iter_divider_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .value  (rem_step),
    .negate (rneg_q),
    .result (r_fixed)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    b_mag_d      = b_mag_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          quo_d   = a_mag;
          b_mag_d = b_mag;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          state_d = StCalc;
        end
      end
      StCalc: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          dout_d       = {q_fixed, r_fixed};
          dout_valid_d = 1'b1;
          state_d      = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      b_mag_q      <= '0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      b_mag_q      <= b_mag_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign s_axis_dividend_tready = (state_q == StIdle);
  assign s_axis_divisor_tready  = (state_q == StIdle);
  assign m_axis_dout_tdata      = dout_q;
  assign m_axis_dout_tvalid     = dout_valid_q;

endmodule
